uart_tx: RTL
============

Name: uart_tx

Overview:
Transmit-side UART serialiser. It is the upstream counterpart of the receiver and drives the serial line that the receiver samples.
- Accepts one parallel word per valid/ready handshake.
- Emits start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Each serial bit is held for exactly CLK_DIVIDE clocks.
- Sits between the host-side byte source and the pad/loopback to uart_rx.

Parameters:
- DATA_WIDTH, 8: payload bits per frame (5..9 supported).
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 19200: line bit rate; CLK_DIVIDE = CLK_FREQ / BAUD_RATE (integer division, must be >= 2).
- PARITY_EN, 0: 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, input, 1: single system clock, all logic on the rising edge.
- rst, input, 1: synchronous, active-low reset (0 = reset).
- tx_data, input, DATA_WIDTH: word to send; sampled only at handshake.
- tx_valid, input, 1: source has a word.
- tx_ready, output, 1: block can accept a word.
- tx, output, 1: serial line, idle high.
- tx_busy, output, 1: frame in progress.
- tx_done, output, 1: one-cycle pulse at frame completion.

Behaviour:
- Reset (rst = 0 at an edge):
  - state goes to IDLE; tx = 1, tx_busy = 0, tx_done = 0; counters and shift register cleared.
  - tx_ready = 1 once out of reset.
  - All outputs except tx_ready are registered. tx_ready = (state == IDLE), decoded from the state register.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - A transfer occurs on an edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register, and the bit counter and bit index are cleared.
  - State goes to START and tx_busy goes to 1.
  - tx_valid while not ready is ignored: no queueing, no error.
- Line timing:
  - tx = 0 from the edge after acceptance, for CLK_DIVIDE cycles (START).
  - DATA: bit i (i = 0..DATA_WIDTH-1, LSB first) is driven for CLK_DIVIDE cycles each.
  - PARITY (only if PARITY_EN = 1): driven for CLK_DIVIDE cycles.
    - Even: XOR of the latched data.
    - Odd: inverted XOR of the latched data.
  - STOP: tx = 1 for STOP_BITS × CLK_DIVIDE cycles.
- Bit counter: counts 0..CLK_DIVIDE-1. Advance to the next bit or state when it equals CLK_DIVIDE-1, then wrap to 0.
- Completion:
  - On the final stop cycle the state goes to IDLE.
  - tx_done = 1 for exactly one cycle, coinciding with tx_busy = 0 and tx_ready = 1.
  - Frame length from the acceptance edge to the tx_done rise is (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLK_DIVIDE cycles.
- Back-to-back: a word with tx_valid held high is accepted in the tx_done cycle. Its start bit follows immediately, with no extra idle cycle.
- Held input: tx_data changes after acceptance do not affect the frame in flight.
- Reset mid-frame: the frame is aborted and tx returns to 1 on the reset edge. No tx_done is produced.
- tx is glitch-free: driven directly from a flop, never from combinational decode.
- Illegal state encoding recovers to IDLE with tx = 1.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum typedef;
  - a function clk_divide(CLK_FREQ, BAUD_RATE);
  - the parity-calculation function, reusable by a future parity-checking receiver.
- One natural sub-module, uart_baud_counter:
  - parameterised by CLK_DIVIDE;
  - inputs: clear and enable;
  - output: bit_end pulse when the count equals CLK_DIVIDE-1.
- State, shift register and parity logic stay in uart_tx.

Test Plan:
All scenarios override CLK_FREQ = 160 and BAUD_RATE = 10, so CLK_DIVIDE = 16.
- Reset: hold rst = 0 for 3 cycles with tx_valid = 1 -> tx = 1, tx_busy = 0, tx_done = 0 throughout; after release, tx_ready = 1.
- Single frame: send 8'hA5, default parameters.
  - tx sequence, each level 16 cycles: 0, 1, 0, 1, 0, 0, 1, 0, 1, then stop 1.
  - tx_done pulses exactly 160 cycles after the acceptance edge.
- Parity: PARITY_EN = 1.
  - 8'hA5, even -> parity bit 0.
  - 8'hA5, odd -> parity bit 1.
  - 8'h07, even -> parity bit 1.
  - Frame length 176 cycles.
- Back-to-back and stop bits: STOP_BITS = 2, tx_valid held high with 8'h3C then 8'hC3.
  - Second start bit begins on the cycle after tx_done.
  - Each frame is 176 cycles.
  - tx_valid pulses during a frame are ignored.
- Reset mid-frame: assert rst = 0 during data bit 3 of 8'hFF.
  - tx = 1 on the next edge, no tx_done.
  - A subsequent 8'h5A frame is correct.
- Loopback: tx drives the rx input of a uart_rx instance with matching parameters (its reset tied to ~rst).
  - Send 8'h3C, 8'h00, 8'hFF.
  - uart_rx reports each value after its frame completes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   tx_state_e   : transmitter state encoding
//   clk_divide() : clocks per serial bit for a given clock/baud pair
//   parity_bit() : even/odd parity over a data word (zero-extended to MAX_DATA_WIDTH)
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  function automatic int clk_divide(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Zero-extension of narrower words does not change the XOR, so one width serves all.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the UART transmitter.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   clear   : restart the bit period at count 0
//   enable  : advance the count this cycle
//   bit_end : high on the last clock of a bit period (count == CLK_DIVIDE-1)
module uart_baud_counter #(
  parameter int CLK_DIVIDE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIVIDE);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIVIDE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign bit_end = enable && !clear && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serialiser: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, then STOP_BITS stop bits, each held CLK_DIVIDE clocks.
//   clk      : system clock
//   rst      : synchronous active-low reset
//   tx_data  : word to send, captured on the tx_valid && tx_ready edge
//   tx_valid : source has a word
//   tx_ready : idle and able to accept a word
//   tx       : serial line, idle high, driven straight from a flop
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse when the last stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CLK_DIVIDE = clk_divide(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W      = 4;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                      accept;
  logic                      bit_end;
  logic [MAX_DATA_WIDTH-1:0] data_ext;

  assign tx_ready = (state_q == TX_IDLE);
  assign accept   = tx_ready && tx_valid;
  assign data_ext = MAX_DATA_WIDTH'(tx_data);

  uart_baud_counter #(
    .CLK_DIVIDE(CLK_DIVIDE)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state_q != TX_IDLE),
    .bit_end(bit_end)
  );

  // tx_d carries the level of the upcoming bit so the line changes on the
  // same edge as the state, with no decode between flop and pin.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_valid) begin
          state_d  = TX_START;
          shift_d  = tx_data;
          idx_d    = '0;
          parity_d = parity_bit(data_ext, PARITY_ODD != 0);
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = TX_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = TX_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_d = TX_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TX_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
